// File: rtl/math_divider_nr_seq.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
// Ports: clk, rst (async, active-high), start/dividend/divisor in;
//   busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
module math_divider_nr_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t        r_state;
  logic [W:0]    r_p;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_d;
  logic [CW-1:0] r_cnt;

  logic [W:0] w_dext;
  logic [W:0] w_shift;
  logic [W:0] w_pnext;
  logic [W:0] w_rfix;

  // The partial remainder wraps modulo 2^(W+1) after the shift;
  // the true post-add/subtract value lies in [-D, D), so the
  // wrapped result and its sign bit are still exact.
  always_comb begin
    w_dext  = {1'b0, r_d};
    w_shift = {r_p[W-1:0], r_q[W-1]};
    w_pnext = r_p[W] ? (w_shift + w_dext)
                     : (w_shift - w_dext);
    w_rfix  = r_p[W] ? (r_p + w_dext) : r_p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_d     <= divisor;
            r_q     <= dividend;
            r_p     <= '0;
            r_cnt   <= CW'(W - 1);
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_p   <= w_pnext;
          r_q   <= {r_q[W-2:0], ~w_pnext[W]};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          // A zero divisor falls out naturally: every step subtracts
          // zero, so all quotient bits are 1 and r_p ends as dividend.
          quotient    <= r_q;
          remainder   <= w_rfix[W-1:0];
          div_by_zero <= (r_d == '0);
          busy        <= 1'b0;
          done        <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_math_divider_nr_seq.sv
// Directed and randomized self-checking bench for
// math_divider_nr_seq at W=8 and W=16.
module tb_math_divider_nr_seq;

  logic clk = 1'b0;
  logic rst;

  logic        s8;
  logic [7:0]  dd8, dv8;
  logic        busy8, done8, z8;
  logic [7:0]  q8, r8;

  logic        s16;
  logic [15:0] dd16, dv16;
  logic        busy16, done16, z16;
  logic [15:0] q16, r16;

  int checks = 0;
  int errs   = 0;

  logic [7:0] lq, lr;
  logic       lz;

  always #5 clk = ~clk;

  math_divider_nr_seq #(.W(8)) u8 (
    .clk         (clk),
    .rst         (rst),
    .start       (s8),
    .dividend    (dd8),
    .divisor     (dv8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  math_divider_nr_seq #(.W(16)) u16 (
    .clk         (clk),
    .rst         (rst),
    .start       (s16),
    .dividend    (dd16),
    .divisor     (dv16),
    .busy        (busy16),
    .done        (done16),
    .quotient    (q16),
    .remainder   (r16),
    .div_by_zero (z16)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Call at #1 after an edge; start is sampled at the next edge
  // (edge 0). Verifies busy/done timing and that the previous
  // results hold until FIX. inj>0 pulses start with 9/2 at edge inj.
  task automatic run8(input string tag,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic ez, input int inj);
    logic ok;
    ok  = 1'b1;
    s8  = 1'b1;
    dd8 = a;
    dv8 = b;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) s8 = 1'b0;
      if (!busy8 || done8 || q8 !== lq || r8 !== lr || z8 !== lz)
        ok = 1'b0;
      if (inj > 0 && k == inj - 1) begin
        s8  = 1'b1;
        dd8 = 8'd9;
        dv8 = 8'd2;
      end
      if (inj > 0 && k == inj) s8 = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, "_timing"}, 32'(ok), 32'd1);
    check({tag, "_busy"}, 32'(busy8), 32'd0);
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_q"}, 32'(q8), 32'(eq));
    check({tag, "_r"}, 32'(r8), 32'(er));
    check({tag, "_dbz"}, 32'(z8), 32'(ez));
    lq = eq;
    lr = er;
    lz = ez;
  endtask

  initial begin
    logic seen;
    rst  = 1'b1;
    s8   = 1'b0;
    dd8  = '0;
    dv8  = '0;
    s16  = 1'b0;
    dd16 = '0;
    dv16 = '0;
    lq   = '0;
    lr   = '0;
    lz   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_q", 32'(q8), 32'd0);
    check("rst_r", 32'(r8), 32'd0);
    check("rst_dbz", 32'(z8), 32'd0);
    rst = 1'b0;

    run8("basic",  8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 0);
    run8("c255_1", 8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 0);
    run8("c0_3",   8'd0,   8'd3,   8'd0,   8'd0, 1'b0, 0);
    run8("c7_200", 8'd7,   8'd200, 8'd0,   8'd7, 1'b0, 0);
    run8("c255",   8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 0);
    run8("ignore", 8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 3);
    run8("ondone", 8'd9,   8'd2,   8'd4,   8'd1, 1'b0, 0);
    run8("dbz",    8'd5,   8'd0,   8'd255, 8'd5, 1'b1, 0);

    s8  = 1'b1;
    dd8 = 8'd100;
    dv8 = 8'd7;
    @(posedge clk);
    #1;
    s8 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_q", 32'(q8), 32'd0);
    check("arst_r", 32'(r8), 32'd0);
    check("arst_dbz", 32'(z8), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) seen = 1'b1;
    end
    check("arst_nodone", 32'(seen), 32'd0);
    lq = '0;
    lr = '0;
    lz = 1'b0;
    run8("post", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 0);

    fork
      begin : rnd8
        logic [7:0] a, b, eq, er;
        logic       got;
        for (int n = 0; n < 7000; n++) begin
          a = 8'($urandom);
          b = 8'($urandom);
          if (n % 40 == 0) b = '0;
          if (b == '0) begin
            eq = 8'hFF;
            er = a;
          end else begin
            eq = a / b;
            er = a % b;
          end
          s8  = 1'b1;
          dd8 = a;
          dv8 = b;
          @(posedge clk);
          #1;
          s8  = 1'b0;
          got = 1'b0;
          for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (done8) got = 1'b1;
          end
          check("r8_done", 32'(got), 32'd1);
          check("r8_q", 32'(q8), 32'(eq));
          check("r8_r", 32'(r8), 32'(er));
          check("r8_dbz", 32'(z8), 32'(b == '0));
        end
      end
      begin : rnd16
        logic [15:0] a, b, eq, er;
        logic        got;
        for (int n = 0; n < 3000; n++) begin
          a = 16'($urandom);
          b = 16'($urandom);
          if (n % 3 == 1) b = 16'($urandom_range(1, 255));
          if (n % 40 == 0) b = '0;
          if (b == '0) begin
            eq = 16'hFFFF;
            er = a;
          end else begin
            eq = a / b;
            er = a % b;
          end
          s16  = 1'b1;
          dd16 = a;
          dv16 = b;
          @(posedge clk);
          #1;
          s16 = 1'b0;
          got = 1'b0;
          for (int k = 0; k < 30 && !got; k++) begin
            @(posedge clk);
            #1;
            if (done16) got = 1'b1;
          end
          check("r16_done", 32'(got), 32'd1);
          check("r16_busy", 32'(busy16), 32'd0);
          check("r16_q", 32'(q16), 32'(eq));
          check("r16_r", 32'(r16), 32'(er));
          check("r16_dbz", 32'(z16), 32'(b == '0));
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/math_divider_nr_seq.md
MATH_DIVIDER_NR_SEQ -- requirements
Module: math_divider_nr_seq

Interface
REQ-001 Parameter: W, default 8, operand and result width in bits (legal W >= 2).
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a division; sampled on the rising edge of clk.
REQ-005 Port: dividend  input  W  unsigned dividend; sampled with an accepted start.
REQ-006 Port: divisor  input  W  unsigned divisor; sampled with an accepted start.
REQ-007 Port: busy  output  1  high while a division is in progress.
REQ-008 Port: done  output  1  one-cycle pulse when results become valid.
REQ-009 Port: quotient  output  W  unsigned quotient.
REQ-010 Port: remainder  output  W  unsigned remainder, always less than divisor when divisor != 0.
REQ-011 Port: div_by_zero  output  1  high with results when the latched divisor was 0.

Function
REQ-012 The block SHALL implement unsigned non-restoring division, one quotient bit per clock, with a W+1-bit signed partial remainder.
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIX.
- IDLE -> RUN on start.
- RUN -> FIX after W iterations.
- FIX -> IDLE after one cycle.
REQ-014 A start SHALL be accepted only in IDLE; start in RUN or FIX SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-015 On accept, the block SHALL latch dividend and divisor, clear the partial remainder, load the iteration counter with W-1, and set busy=1 from the next cycle.
REQ-016 Each RUN cycle SHALL update the remainder and shift one quotient bit in.
- Shift {remainder, quotient register} left by one bit.
- Subtract the divisor if the partial remainder is >= 0; otherwise add it.
- Shift in quotient bit 1 if the new remainder is >= 0, else 0.
- Decrement the counter; leave RUN when the counter reaches 0.
REQ-017 In FIX, the block SHALL add the divisor back to the partial remainder if it is negative, then load quotient, remainder and div_by_zero from internal state.
REQ-018 Latency: if start is accepted at edge 0, busy SHALL be 1 after edges 0..W and 0 after edge W+1. done SHALL be 1 only after edge W+1, for exactly one cycle.
REQ-019 quotient, remainder and div_by_zero SHALL change only in FIX, and SHALL hold their values until the next FIX or reset.
REQ-020 A start asserted in the cycle where done=1 SHALL be accepted, since the FSM is then in IDLE; the previous results SHALL remain on the outputs until that division's FIX.
REQ-021 Divisor 0 SHALL take the same W+2 latency with no early exit.
- quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-022 For every divisor != 0: dividend = quotient*divisor + remainder and remainder < divisor, exactly, over the full W-bit range.

Reset
REQ-023 While rst=1, the block SHALL force the FSM to IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all internal registers, asynchronously and independent of clk.
REQ-024 A reset asserted mid-division SHALL abort it, and no done pulse SHALL follow for the aborted operation.
REQ-025 After rst deasserts, the first start SHALL be accepted no earlier than the first rising edge at which rst is sampled low.

Verification
REQ-026 Basic division: W=8, start at edge 0 with 100/7 -> busy=1 after edges 0..8; done=1 after edge 9 only; quotient=14, remainder=2, div_by_zero=0.
REQ-027 Corner operands (W=8):
- 255/1 -> 255 r 0.
- 0/3 -> 0 r 0.
- 7/200 -> 0 r 7.
- 255/255 -> 1 r 0.
- div_by_zero=0 in each case.
REQ-028 Divide by zero: W=8, 5/0 -> quotient=255, remainder=5, div_by_zero=1, done after edge 9.
REQ-029 Handshake: start pulsed with 9/2 at edge 3 of a 100/7 run -> ignored, result 14 r 2. Start held on the done cycle with 9/2 -> accepted; result 4 r 1 with done exactly W+2 edges later.
REQ-030 Reset mid-operation: rst asserted mid-RUN -> all outputs 0 immediately (before the next edge), no done pulse; a following 50/6 -> 8 r 2.
REQ-031 Randomized check: at least 10000 random operand pairs at W=8 and W=16 checked against the REQ-022 identity and the REQ-021 zero rule, with back-to-back starts.
